// File: rtl/seller_multi.sv
// seller_multi: two-product coin vending controller.
//
// Collects 0.5/1/2 yuan coins into a credit register and vends product A or B
// once the credit covers the selected price, returning change. In the middle
// of a transaction a user cancel, or TIMEOUT consecutive coin-free cycles,
// refunds the credit collected so far.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   d1        in   0.5-yuan coin pulse (value 1)
//   d2        in   1-yuan coin pulse (value 2)
//   d3        in   2-yuan coin pulse (value 4)
//   sel       in   product select (0 = A, 1 = B), sampled with the first coin
//   cancel    in   refund request while collecting
//   out1      out  vend pulse
//   out_prod  out  product vended, valid with out1
//   out2      out  change or refund amount in 0.5-yuan units
//   refund    out  refund pulse (cancel or timeout)
//   busy      out  high while a transaction is collecting coins
//
// All amounts are in 0.5-yuan units. All outputs are registered and updated
// from the next-state decode, so they appear one clock after the deciding
// input.

module seller_multi #(
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned PRICE_A  = 3,
  parameter int unsigned PRICE_B  = 5,
  parameter int unsigned TIMEOUT  = 8,
  parameter int unsigned TO_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d1,
  input  logic                d2,
  input  logic                d3,
  input  logic                sel,
  input  logic                cancel,
  output logic                out1,
  output logic                out_prod,
  output logic [CREDIT_W-1:0] out2,
  output logic                refund,
  output logic                busy
);

  // Prices widened to the CREDIT_W+1 bit sum width so the compare never wraps.
  localparam logic [CREDIT_W:0] PriceA  = (CREDIT_W + 1)'(PRICE_A);
  localparam logic [CREDIT_W:0] PriceB  = (CREDIT_W + 1)'(PRICE_B);
  localparam logic [TO_W-1:0]   ToLast  = TO_W'(TIMEOUT - 1);

  // Two-bit encoding leaves spare codes; those fall to the recovery branch.
  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCollect = 2'b01
  } state_e;

  state_e              state;
  logic [CREDIT_W-1:0] credit;
  logic                prod;
  logic [TO_W-1:0]     to_cnt;

  logic [2:0]          coin_val;
  logic                coin;
  logic                cur_prod;
  logic [CREDIT_W:0]   price_sel;
  logic [CREDIT_W:0]   credit_base;
  logic [CREDIT_W:0]   credit_n;
  logic                vend;
  logic [CREDIT_W-1:0] change;
  logic                timeout_hit;

  // Coin decode: one coin per cycle, d1 wins over d2 wins over d3.
  always_comb begin
    coin_val = 3'd0;
    if (d1) begin
      coin_val = 3'd1;
    end else if (d2) begin
      coin_val = 3'd2;
    end else if (d3) begin
      coin_val = 3'd4;
    end
  end

  assign coin = d1 | d2 | d3;

  // In IDLE the product comes straight from sel; afterwards it is latched.
  always_comb begin
    cur_prod    = prod;
    credit_base = {1'b0, credit};
    if (state != StCollect) begin
      cur_prod    = sel;
      credit_base = '0;
    end
  end

  assign price_sel = cur_prod ? PriceB : PriceA;
  assign credit_n  = credit_base + (CREDIT_W + 1)'(coin_val);
  // Without a coin credit_n is 0 in IDLE and prices are >= 1, so no false vend.
  assign vend      = (credit_n >= price_sel);
  assign change    = credit_n[CREDIT_W-1:0] - price_sel[CREDIT_W-1:0];

  // Only a cycle with neither coin nor cancel can expire the transaction.
  assign timeout_hit = (state == StCollect) && !coin && !cancel && (to_cnt == ToLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      credit   <= '0;
      prod     <= 1'b0;
      to_cnt   <= '0;
      out1     <= 1'b0;
      out_prod <= 1'b0;
      out2     <= '0;
      refund   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Pulse outputs default low; out2/out_prod are 0 outside a pulse.
      out1     <= 1'b0;
      out_prod <= 1'b0;
      out2     <= '0;
      refund   <= 1'b0;

      case (state)
        StIdle: begin
          to_cnt <= '0;
          if (coin) begin
            prod <= sel;
            if (vend) begin
              // A single coin already covers the price: vend without collecting.
              out1     <= 1'b1;
              out_prod <= sel;
              out2     <= change;
              credit   <= '0;
              state    <= StIdle;
              busy     <= 1'b0;
            end else begin
              credit <= credit_n[CREDIT_W-1:0];
              state  <= StCollect;
              busy   <= 1'b1;
            end
          end else begin
            // A cancel with nothing collected is ignored.
            credit <= '0;
            state  <= StIdle;
            busy   <= 1'b0;
          end
        end

        StCollect: begin
          if (vend) begin
            // Vend takes priority over a simultaneous cancel.
            out1     <= 1'b1;
            out_prod <= prod;
            out2     <= change;
            credit   <= '0;
            to_cnt   <= '0;
            state    <= StIdle;
            busy     <= 1'b0;
          end else if (cancel) begin
            // Any coin arriving with the cancel is refunded too.
            refund <= 1'b1;
            out2   <= credit_n[CREDIT_W-1:0];
            credit <= '0;
            to_cnt <= '0;
            state  <= StIdle;
            busy   <= 1'b0;
          end else if (timeout_hit) begin
            refund <= 1'b1;
            out2   <= credit;
            credit <= '0;
            to_cnt <= '0;
            state  <= StIdle;
            busy   <= 1'b0;
          end else begin
            credit <= credit_n[CREDIT_W-1:0];
            to_cnt <= coin ? '0 : to_cnt + TO_W'(1);
            state  <= StCollect;
            busy   <= 1'b1;
          end
        end

        default: begin
          // Unused encoding: drop any credit and return to IDLE.
          state  <= StIdle;
          credit <= '0;
          prod   <= 1'b0;
          to_cnt <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seller_multi.sv
// Testbench for seller_multi: a table of per-cycle vectors followed by
// hand-written timeout and mid-transaction reset sequences.

module tb_seller_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       d1, d2, d3, sel, cancel;
  logic       out1, out_prod, refund, busy;
  logic [3:0] out2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seller_multi #(
    .CREDIT_W(4),
    .PRICE_A (3),
    .PRICE_B (5),
    .TIMEOUT (8),
    .TO_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .sel     (sel),
    .cancel  (cancel),
    .out1    (out1),
    .out_prod(out_prod),
    .out2    (out2),
    .refund  (refund),
    .busy    (busy)
  );

  // One cycle of stimulus and the outputs expected after the following edge.
  typedef struct {
    logic       d1;
    logic       d2;
    logic       d3;
    logic       sel;
    logic       cancel;
    logic       o1;
    logic       op;
    logic [3:0] o2;
    logic       rf;
    logic       bz;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a, b, c, s, cn, o1, op, input logic [3:0] o2,
                     input logic rf, bz);
    vec_t v;
    v.d1 = a; v.d2 = b; v.d3 = c; v.sel = s; v.cancel = cn;
    v.o1 = o1; v.op = op; v.o2 = o2; v.rf = rf; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic o1, op, input logic [3:0] o2,
                           input logic rf, bz);
    chk({tag, " out1"}, int'(out1), int'(o1));
    chk({tag, " out_prod"}, int'(out_prod), int'(op));
    chk({tag, " out2"}, int'(out2), int'(o2));
    chk({tag, " refund"}, int'(refund), int'(rf));
    chk({tag, " busy"}, int'(busy), int'(bz));
  endtask

  task automatic drive(input logic a, b, c, s, cn);
    @(negedge clk);
    d1 = a; d2 = b; d3 = c; sel = s; cancel = cn;
  endtask

  // Apply one cycle of inputs and check outputs just after the capturing edge.
  task automatic step(input string tag, input logic a, b, c, s, cn,
                      input logic o1, op, input logic [3:0] o2, input logic rf, bz);
    drive(a, b, c, s, cn);
    @(posedge clk);
    #1;
    check_all(tag, o1, op, o2, rf, bz);
  endtask

  initial begin
    rst = 1'b0;
    d1 = 0; d2 = 0; d3 = 0; sel = 0; cancel = 0;

    //   d1 d2 d3 sel can | out1 prod out2 ref busy
    // Three half-yuan coins buy A exactly.
    add(1, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    add(1, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    add(1, 0, 0, 0, 0,   1, 0, 4'd0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);
    // Single 2-yuan coin vends A straight from IDLE with 0.5 change.
    add(0, 0, 1, 0, 0,   1, 0, 4'd1, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);
    // Product B latched on first coin; later sel=0 ignored.
    add(0, 1, 0, 1, 0,   0, 0, 4'd0, 0, 1);
    add(0, 0, 1, 0, 0,   1, 1, 4'd1, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);
    // Cancel with a coin in the same cycle refunds both coins.
    add(1, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    add(1, 0, 0, 0, 1,   0, 0, 4'd2, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);
    // d1 beats d3, then d2 makes exactly 3.
    add(1, 0, 1, 0, 0,   0, 0, 4'd0, 0, 1);
    add(0, 1, 0, 0, 0,   1, 0, 4'd0, 0, 0);
    // Coin during the vend pulse starts a new B transaction.
    add(0, 0, 1, 1, 0,   0, 0, 4'd0, 0, 1);
    add(0, 1, 0, 0, 0,   1, 1, 4'd1, 0, 0);
    // Coin during that pulse vends A immediately.
    add(0, 0, 1, 0, 0,   1, 0, 4'd1, 0, 0);
    // Cancel in IDLE is ignored.
    add(0, 0, 0, 0, 1,   0, 0, 4'd0, 0, 0);
    // Vend wins over cancel when the coin completes the price.
    add(0, 1, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    add(1, 0, 0, 0, 1,   1, 0, 4'd0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);
    // d2 beats d3 (credit 2, no vend of B), then cancel refunds 2.
    add(0, 1, 1, 1, 0,   0, 0, 4'd0, 0, 1);
    add(0, 0, 0, 0, 1,   0, 0, 4'd2, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);
    // Maximum change: 2 + 2 + 4 = 8 for B, change 3.
    add(0, 1, 0, 1, 0,   0, 0, 4'd0, 0, 1);
    add(0, 1, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    add(0, 0, 1, 0, 0,   1, 1, 4'd3, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].sel,
           vecs[i].cancel, vecs[i].o1, vecs[i].op, vecs[i].o2, vecs[i].rf, vecs[i].bz);
    end

    // Timeout: d2 for B, then 8 coin-free cycles refund 2 on the 8th edge.
    step("to_a coin", 0, 1, 0, 1, 0,   0, 0, 4'd0, 0, 1);
    for (int i = 1; i <= 7; i++) begin
      step($sformatf("to_a idle%0d", i), 0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    end
    step("to_a idle8", 0, 0, 0, 0, 0,   0, 0, 4'd2, 1, 0);
    step("to_a after", 0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);

    // Timeout restart: coin at idle cycle 5 clears the count.
    step("to_b coin", 0, 1, 0, 1, 0,   0, 0, 4'd0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("to_b idle%0d", i), 0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    end
    step("to_b idle5 coin", 1, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    for (int i = 1; i <= 7; i++) begin
      step($sformatf("to_b re%0d", i), 0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    end
    step("to_b re8", 0, 0, 0, 0, 0,   0, 0, 4'd3, 1, 0);
    step("to_b after", 0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 0);

    // Reset mid-collect forfeits credit and clears outputs at once.
    step("rst coin", 0, 1, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    @(negedge clk);
    d1 = 0; d2 = 0; d3 = 0; sel = 0; cancel = 0;
    rst = 1'b0;
    #1;
    check_all("rst async", 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step("rst d1", 1, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    step("rst idle", 0, 0, 0, 0, 0,   0, 0, 4'd0, 0, 1);
    step("rst cancel", 0, 0, 0, 0, 1,   0, 0, 4'd1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seller_multi.md
Name: seller_multi

Overview:
- Parametrised successor to the single-product coin FSM.
- Accumulates coins of 0.5/1/2 yuan into a credit register and sells one of two products with programmable prices.
- Returns change and supports user cancel and an inactivity-timeout refund.
- Sits between the coin acceptor front-end (one-cycle coin pulses) and the dispense/change actuators.

Parameters:
- CREDIT_W, 4, width of credit and change in 0.5-yuan units; must hold max(PRICE_A,PRICE_B)+3.
- PRICE_A, 3, price of product 0 in 0.5-yuan units (3 = 1.5 yuan); range 1..2^CREDIT_W-4.
- PRICE_B, 5, price of product 1 in 0.5-yuan units (5 = 2.5 yuan); same range.
- TIMEOUT, 8, consecutive coin-free COLLECT cycles before auto-refund, ≥2.
- TO_W, 4, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- d1  in  1  0.5-yuan coin pulse (value 1)
- d2  in  1  1-yuan coin pulse (value 2)
- d3  in  1  2-yuan coin pulse (value 4)
- sel  in  1  product select: 0 = A, 1 = B; sampled on first coin only
- cancel  in  1  request refund of current credit
- out1  out  1  vend pulse
- out_prod  out  1  product vended; valid with out1
- out2  out  CREDIT_W  change/refund amount in 0.5-yuan units; valid with out1 or refund
- refund  out  1  refund pulse (cancel or timeout)
- busy  out  1  high while state is COLLECT

Behaviour:
- Reset (async, rst=0): state IDLE, credit=0, latched sel=0, timeout count=0; out1, out_prod, out2, refund, busy all 0.
- Coin decode: one coin per cycle; priority d1 > d2 > d3; lower-priority simultaneous coins are discarded. coin_val ∈ {0,1,2,4}.
- State IDLE:
  - busy=0.
  - A coin latches sel as product p, sets credit_n = coin_val, and goes to COLLECT.
  - If coin_val ≥ price(p), it goes directly to vend (e.g. d3 with PRICE_A=3).
  - cancel with no coin: ignored.
- State COLLECT:
  - busy=1; sel changes are ignored.
  - Each cycle: credit_n = credit + coin_val, computed in CREDIT_W+1 bits.
  - Vend when credit_n ≥ price(p).
  - A coin clears the timeout counter; a coin-free cycle increments it.
- Vend: next edge sets out1=1, out_prod=p, out2=credit_n-price(p), refund=0; credit cleared; state IDLE.
- Cancel in COLLECT:
  - A coin arriving in the same cycle is added first.
  - If credit_n ≥ price, vend wins over cancel.
  - Otherwise next edge: refund=1, out2=credit_n, out1=0; credit cleared; state IDLE.
- Timeout: when the counter reaches TIMEOUT-1 on a coin-free, cancel-free cycle, next edge behaves as cancel: refund=1, out2=credit.
- Output timing:
  - All outputs are registered and depend on next-state decode.
  - Latency is 1 clock from the deciding coin/cancel edge.
  - out1/refund are exactly 1-cycle pulses; out2 and out_prod are 0 whenever out1=0 and refund=0.
- Back-to-back purchases: a coin in the cycle the vend/refund pulse is high is accepted as the first coin of a new transaction, with sel sampled that cycle.
- Width: credit never exceeds price+3 < 2^CREDIT_W by parameter constraint; no wrap. Illegal state encodings recover to IDLE with credit 0.
- Reset mid-transaction: credit is forfeited and outputs clear immediately; no refund pulse.

Test Plan:
- Defaults, sel=0, d1 on 3 consecutive cycles -> 1 cycle after 3rd coin: out1=1, out_prod=0, out2=0, for one cycle; busy drops.
- sel=0, single d3 from IDLE -> next cycle out1=1, out2=1; busy never set high.
- sel=1 then sel=0 during collect, d2 then d3 -> product B kept: out1=1, out_prod=1, out2=1.
- sel=0, d1 then cancel with d1 in the same cycle -> refund=1, out2=2, out1=0.
- sel=1, d2 then 8 idle cycles -> refund=1 with out2=2 on the edge after the 8th idle cycle; one extra coin at idle cycle 5 restarts the count.
- d1 & d3 together, then d2 in COLLECT -> credit 1 then 3, vends A with out2=0. Separately: d2 then rst low mid-collect -> all outputs 0, busy=0; subsequent lone d1 produces no vend.
